q_flop_array: RTL and testbench

//  Parametrised, multi-bit, clocked successor of the single-bit Q-flop. WIDTH asynchronous data bits

---
 rtl/q_pkg.sv | 21 ++
 rtl/q_fifo.sv | 64 ++++++
 rtl/q_flop_array.sv | 153 +++++++++++++++
 tb/tb_q_flop_array.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/q_pkg.sv
// rtl/q_pkg.sv - shared state encoding and width helpers for q_flop_array
package q_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_PUSH   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Bits needed to hold any value 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   // A queued entry is the data word plus one error flag above it.
   function automatic int entry_width(input int data_width);
      return data_width + 1;
   endfunction

endpackage

// File: rtl/q_fifo.sv
// rtl/q_fifo.sv - show-ahead FIFO holding captured words with their error flag
module q_fifo
   import q_pkg::*;
#(
   parameter int W     = 9,
   parameter int DEPTH = 4
)
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [W-1:0]                 wdata,
   input  logic                         pop_ready,
   output logic [W-1:0]                 rdata,
   output logic                         valid,
   output logic                         can_push,
   output logic [cnt_width(DEPTH)-1:0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_width(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          do_pop;
   logic          do_push;

   // A pop frees a slot in the same cycle, so a full FIFO can still accept.
   assign valid    = (count != '0);
   assign full     = (count == FULL_CNT);
   assign do_pop   = valid && pop_ready;
   assign can_push = !full || do_pop;
   assign do_push  = push && can_push;
   // Head is gated so an empty FIFO presents zero rather than stale storage.
   assign rdata    = valid ? mem[rd_ptr] : '0;

   // Storage array: written only, never reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/q_flop_array.sv
// rtl/q_flop_array.sv - multi-bit synchronising capture with settle/timeout and output FIFO
module q_flop_array
   import q_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int SETTLE      = 2,
   parameter int TIMEOUT     = 15,
   parameter int DEPTH       = 4
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          data,
   input  logic                      req,
   output logic                      ack,
   output logic                      busy,
   output logic [WIDTH-1:0]          out,
   output logic                      out_err,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int EW = entry_width(WIDTH);
   localparam int SW = cnt_width(SETTLE);
   localparam int TW = cnt_width(TIMEOUT);
   localparam logic [SW-1:0] STAB_MAX = SW'(SETTLE);
   localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT);

   logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
   logic [WIDTH-1:0] sync_q;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [SW-1:0]    stab_q, stab_d;
   logic [TW-1:0]    wait_q, wait_d;
   logic             err_q, err_d;
   logic             ack_q, ack_d;
   logic             push;
   logic             can_push;
   logic [EW-1:0]    head;

   assign sync_q = sync_ff[SYNC_STAGES-1];

   // Per-bit synchroniser chain; the last stage is the only one the FSM looks at.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
      end else begin
         sync_ff[0] <= data;
         for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
      end
   end

   // Capture FSM and its settle/timeout counters, all registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         prev_q  <= '0;
         word_q  <= '0;
         stab_q  <= '0;
         wait_q  <= '0;
         err_q   <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         word_q  <= word_d;
         stab_q  <= stab_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         ack_q   <= ack_d;
      end
   end

   // Next-state: resolve is tested before timeout so it wins a tie.
   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      word_d  = word_q;
      stab_d  = stab_q;
      wait_d  = wait_q;
      err_d   = err_q;
      ack_d   = ack_q;
      push    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d = ST_SETTLE;
               prev_d  = sync_q;
               stab_d  = '0;
               wait_d  = '0;
            end
         end
         ST_SETTLE: begin
            if (stab_q == STAB_MAX) begin
               state_d = ST_PUSH;
               word_d  = prev_q;
               err_d   = 1'b0;
            end else if (wait_q == WAIT_MAX) begin
               state_d = ST_PUSH;
               word_d  = sync_q;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
               if (sync_q == prev_q) begin
                  stab_d = stab_q + 1'b1;
               end else begin
                  stab_d = '0;
                  prev_d = sync_q;
               end
            end
         end
         ST_PUSH: begin
            if (can_push) begin
               push    = 1'b1;
               ack_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!req) begin
               ack_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   q_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .wdata     ({err_q, word_q}),
      .pop_ready (out_ready),
      .rdata     (head),
      .valid     (out_valid),
      .can_push  (can_push),
      .count     (count)
   );

   assign ack     = ack_q;
   assign busy    = (state_q != ST_IDLE);
   assign out     = head[WIDTH-1:0];
   assign out_err = head[WIDTH];

endmodule

// File: tb/tb_q_flop_array.sv
// tb/tb_q_flop_array.sv - randomized self-checking bench for q_flop_array
module tb_q_flop_array;

   localparam int WIDTH   = 8;
   localparam int SS      = 2;
   localparam int SETTLE  = 2;
   localparam int TIMEOUT = 15;
   localparam int DEPTH   = 4;
   localparam int CW      = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] data;
   logic             req;
   logic             ack;
   logic             busy;
   logic [WIDTH-1:0] out;
   logic             out_err;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    count;

   q_flop_array #(
      .WIDTH(WIDTH), .SYNC_STAGES(SS), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .data(data), .req(req), .ack(ack), .busy(busy),
      .out(out), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready), .count(count)
   );

   always #5 clk = ~clk;

   // Edge index and the data value sampled at every rising edge.
   int               cyc = 0;
   logic [WIDTH-1:0] hist [0:8191];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      hist[(cyc + 1) & 8191] <= data;
   end

   int               n_checks = 0;
   int               n_fail   = 0;
   logic [WIDTH:0]   mq [$];
   int               mode = 0;
   int               sc   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One cycle: wait for the falling edge, then apply the data pattern for the next edge.
   task automatic step();
      @(negedge clk);
      case (mode)
         1: data = ~data;
         2: data = WIDTH'($urandom);
         3: begin data = (sc < SETTLE - 1) ? 8'h3C : 8'hC3; sc++; end
         4: data = $urandom_range(0, 1) ? 8'h11 : 8'h22;
         default: ;
      endcase
   endtask

   task automatic set_stable(input logic [WIDTH-1:0] v);
      mode = 0;
      data = v;
      repeat (3) step();
   endtask

   // Synchronised value seen just before edge r+k.
   function automatic logic [WIDTH-1:0] s_at(input int r, input int k);
      return hist[(r + k - SS) & 8191];
   endfunction

   // Reference: the capture resolves at the first edge that follows SETTLE+1 equal
   // synchronised samples, else is forced TIMEOUT+1 edges after the request.
   task automatic model(input int r, output int e, output logic [WIDTH-1:0] w, output logic er);
      bit done;
      e = 0; w = '0; er = 1'b0; done = 0;
      for (int k = 1; k <= TIMEOUT + 1 && !done; k++) begin
         if (k - 1 >= SETTLE) begin
            bit same;
            same = 1;
            for (int j = k - 1 - SETTLE; j < k - 1; j++)
               if (s_at(r, j) != s_at(r, j + 1)) same = 0;
            if (same) begin e = k; w = s_at(r, k - 1); er = 1'b0; done = 1; end
         end
         if (!done && k - 1 == TIMEOUT) begin e = k; w = s_at(r, k); er = 1'b1; done = 1; end
      end
   endtask

   task automatic capture(input string tag, input bit early_drop);
      int r, e;
      logic [WIDTH-1:0] w;
      logic er;
      bit got;
      step();
      req = 1'b1;
      r = cyc + 1;
      got = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         step();
         if (early_drop && i == 0) req = 1'b0;
         if (ack) got = 1;
      end
      check({tag, "_ack_seen"}, 32'(got), 32'd1);
      if (got) begin
         model(r, e, w, er);
         check({tag, "_latency"}, cyc, r + e + 1);
         mq.push_back({er, w});
         check({tag, "_count"}, 32'(count), mq.size());
         check({tag, "_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_head"}, {23'd0, out_err, out}, 32'(mq[0]));
      end
      req = 1'b0;
      step();
      check({tag, "_ack_low"}, 32'(ack), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      while (mq.size() > 0) begin
         check({tag, "_head"}, {23'd0, out_err, out}, 32'(mq[0]));
         check({tag, "_cnt"}, 32'(count), mq.size());
         step();
         void'(mq.pop_front());
      end
      check({tag, "_empty"}, 32'(out_valid), 32'd0);
      out_ready = 1'b0;
   endtask

   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      req = 1'b0;
      #1;
      check({tag, "_ack"}, 32'(ack), 32'd0);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_count"}, 32'(count), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      mq.delete();
      step();
      rst = 1'b0;
      repeat (SS + 2) step();
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; out_ready = 1'b0; data = 8'hA5;
      #1;
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_out", 32'(out), 32'd0);
      repeat (2) step();
      rst = 1'b0;
      repeat (SS + 2) step();

      // Stable word resolves with the nominal latency.
      set_stable(8'hA5);
      capture("t1", 0);
      check("t1_out", 32'(out), 32'hA5);
      check("t1_err", 32'(out_err), 32'd0);
      drain("t1d");

      // Word toggling every cycle only completes on timeout.
      mode = 1;
      capture("t2", 0);
      mode = 0;
      check("t2_err", 32'(out_err), 32'd1);
      drain("t2d");

      // Four captures fill the FIFO; the fifth waits in PUSH until a pop frees a slot.
      for (int i = 0; i < DEPTH; i++) begin
         set_stable(WIDTH'($urandom));
         capture("t3_fill", 0);
      end
      set_stable(8'h5A);
      step();
      req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 8) mode = 2;
      end
      mode = 0;
      check("t3_wait_ack", 32'(ack), 32'd0);
      check("t3_wait_busy", 32'(busy), 32'd1);
      check("t3_wait_count", 32'(count), DEPTH);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      void'(mq.pop_front());
      mq.push_back({1'b0, 8'h5A});
      check("t3_push_ack", 32'(ack), 32'd1);
      check("t3_push_count", 32'(count), DEPTH);
      req = 1'b0;
      step();
      check("t3_ack_low", 32'(ack), 32'd0);
      drain("t3d");

      // Asynchronous reset in SETTLE with three words queued.
      for (int i = 0; i < 3; i++) begin
         set_stable(WIDTH'($urandom));
         capture("t4_fill", 0);
      end
      step();
      req = 1'b1;
      repeat (2) step();
      check("t4_in_settle", 32'(busy), 32'd1);
      async_reset("t4_rst");
      set_stable(8'h96);
      capture("t4_after", 0);
      check("t4_after_out", 32'(out), 32'h96);
      drain("t4d");

      // Request dropped early: capture still completes, ack lasts one cycle.
      set_stable(8'h71);
      capture("t5", 1);
      drain("t5d");

      // Short-lived value must restart the stability count.
      set_stable(8'h00);
      mode = 3; sc = 0;
      capture("t6", 0);
      mode = 0;
      check("t6_out", 32'(out), 32'hC3);
      check("t6_err", 32'(out_err), 32'd0);
      drain("t6d");

      // Randomised mix of stable, noisy and two-valued inputs.
      for (int it = 0; it < 12; it++) begin
         int m;
         m = $urandom_range(0, 2);
         if (m == 0) set_stable(WIDTH'($urandom));
         else mode = (m == 1) ? 2 : 4;
         capture("rnd", 0);
         mode = 0;
         if (mq.size() >= DEPTH - 1) drain("rnd_d");
      end
      drain("rnd_end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
